// File: rtl/rsa_core_arbiter.sv
// rsa_core_arbiter: round-robin scheduler sharing one rsa_decoder core among NREQ requesters,
// sequencing start/done with a watchdog that aborts jobs whose core never finishes.
module rsa_core_arbiter #(
    parameter int K       = 12,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 4096,
    parameter int TW      = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*K-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [K-1:0]      rsp_data,
    output logic              rsp_err,
    output logic              core_start,
    output logic [K-1:0]      core_data,
    input  logic              core_done,
    input  logic [K-1:0]      core_result,
    output logic              busy
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

    state_t        state;
    logic [PW-1:0] ptr, gnt, nxt;
    logic [PW:0]   sum;
    logic          hit, err;
    logic [TW-1:0] wdog;

    // Scan ptr+NREQ down to ptr+1 so the closest requester after ptr is written last and wins.
    always_comb begin
        nxt = '0;
        hit = 1'b0;
        sum = '0;
        for (int i = NREQ; i >= 1; i--) begin
            sum = {1'b0, ptr} + (PW+1)'(i);
            sum = (sum >= (PW+1)'(NREQ)) ? sum - (PW+1)'(NREQ) : sum;
            if (req_valid[sum[PW-1:0]]) begin
                nxt = sum[PW-1:0];
                hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= PW'(NREQ-1);
            gnt       <= '0;
            wdog      <= '0;
            err       <= 1'b0;
            core_data <= '0;
            rsp_data  <= '0;
        end else begin
            case (state)
                IDLE: if (hit) begin
                    gnt       <= nxt;
                    core_data <= req_data[nxt*K +: K];
                    state     <= LAUNCH;
                end
                LAUNCH: begin
                    wdog  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    wdog <= wdog + 1'b1;
                    if (core_done) begin
                        rsp_data <= core_result;
                        err      <= 1'b0;
                        state    <= RESP;
                    end else if (wdog == TW'(TIMEOUT-1)) begin
                        rsp_data <= '0;
                        err      <= 1'b1;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    ptr   <= gnt;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state == LAUNCH) ? NREQ'(1) << gnt : '0;
    assign rsp_valid  = (state == RESP) ? NREQ'(1) << gnt : '0;
    assign rsp_err    = (state == RESP) && err;
    assign core_start = (state == LAUNCH) || (state == WAIT);
    assign busy       = (state != IDLE);
endmodule

// File: tb/tb_rsa_core_arbiter.sv
// tb_rsa_core_arbiter: directed and randomized jobs against a stub core, checked with a
// pending-set round-robin model.
module tb_rsa_core_arbiter;
    localparam int K = 12, NREQ = 4, TO = 16;

    logic              clk = 1'b0, rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0, req_ready, rsp_valid;
    logic [NREQ*K-1:0] req_data = '0;
    logic [K-1:0]      rsp_data, core_data, core_result;
    logic              rsp_err, core_start, core_done, busy;
    logic [7:0]        scnt = '0, stub_delay = '0;

    int tests = 0, fails = 0, mptr = NREQ-1, g;
    bit pend [NREQ];
    logic [K-1:0] pdata [NREQ];
    int order [5] = '{0, 1, 2, 3, 0};

    rsa_core_arbiter #(.K(K), .NREQ(NREQ), .TIMEOUT(TO), .TW(5)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .core_start(core_start), .core_data(core_data),
        .core_done(core_done), .core_result(core_result), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stub core: done stub_delay cycles after start rises, result = data + 1.
    always @(posedge clk) scnt <= core_start ? scnt + 8'd1 : 8'd0;
    assign core_done   = core_start && (scnt == stub_delay);
    assign core_result = core_data + 12'd1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NREQ-1:0] oh(input int i);
        return NREQ'(1) << i;
    endfunction

    function automatic int pick();
        for (int k = 1; k <= NREQ; k++)
            if (pend[(mptr + k) % NREQ]) return (mptr + k) % NREQ;
        return 0;
    endfunction

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = pend[i];
            req_data[i*K +: K] = pdata[i];
        end
    endtask

    task automatic run_job(input int delay, output int got_g);
        int e, n;
        logic [K-1:0] ed;
        stub_delay = 8'(delay);
        e = pick();
        drive();
        @(negedge clk);
        got_g = -1;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) got_g = i;
        check("req_ready", req_ready, oh(e));
        check("core_start_launch", core_start, 1);
        check("core_data", core_data, pdata[e]);
        check("busy", busy, 1);
        pend[e] = 1'b0;
        drive();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rsp_valid == 0 && n < 60);
        ed = (delay <= TO) ? pdata[e] + 12'd1 : 12'd0;
        check("rsp_latency", n, 1 + ((delay <= TO) ? delay : TO));
        check("rsp_valid", rsp_valid, oh(e));
        check("rsp_data", rsp_data, ed);
        check("rsp_err", rsp_err, delay > TO);
        check("core_start_resp", core_start, 0);
        mptr = e;
        @(negedge clk);
        check("idle_after_resp", {busy, rsp_valid, req_ready}, 0);
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0;
            pdata[i] = '0;
        end
        repeat (2) @(negedge clk);
        check("reset_outs", {req_ready, rsp_valid, rsp_err, core_start, busy}, 0);
        check("reset_data", {rsp_data, core_data}, 0);
        rst = 1'b0;

        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b1;
            pdata[i] = 12'(10 * (i + 1));
        end
        for (int j = 0; j < 5; j++) begin
            run_job(5, g);
            check("rr_order", g, order[j]);
            pend[g] = 1'b1;
        end
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;

        pend[2] = 1'b1; pdata[2] = 12'd7;
        run_job(3, g);
        check("served_2", g, 2);
        pend[1] = 1'b1; pdata[1] = 12'd100;
        pend[3] = 1'b1; pdata[3] = 12'd300;
        run_job(2, g);
        check("fair_3_before_1", g, 3);
        run_job(2, g);
        check("fair_then_1", g, 1);

        pend[0] = 1'b1; pdata[0] = 12'hABC;
        run_job(100, g);
        pend[1] = 1'b1; pdata[1] = 12'hFFF;
        run_job(3, g);
        pend[0] = 1'b1; pdata[0] = 12'h123;
        run_job(16, g);

        pend[2] = 1'b1; pdata[2] = 12'h055;
        stub_delay = 8'd200;
        drive();
        @(negedge clk);
        check("mid_ready", req_ready, oh(2));
        pend[2] = 1'b0;
        drive();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_outs", {core_start, busy, rsp_valid, req_ready}, 0);
        mptr = NREQ - 1;
        pend[0] = 1'b1; pdata[0] = 12'h321;
        pend[1] = 1'b1; pdata[1] = 12'h654;
        run_job(4, g);
        check("post_rst_grant0", g, 0);
        run_job(4, g);

        for (int j = 0; j < 40; j++) begin
            for (int i = 0; i < NREQ; i++)
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    pdata[i] = 12'($urandom);
                end
            if (!(pend[0] || pend[1] || pend[2] || pend[3])) begin
                pend[j % NREQ] = 1'b1;
                pdata[j % NREQ] = 12'($urandom);
            end
            run_job(int'($urandom_range(1, 20)), g);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rsa_core_arbiter.md
Name: rsa_core_arbiter

Overview:
- Round-robin scheduler that shares one rsa_decoder core among NREQ requesters.
- Accepts one K-bit ciphertext per grant and sequences the core's start/done handshake.
- Returns the result to the granted requester with a one-cycle response pulse.
- A watchdog aborts jobs whose core never signals done.
- Sits between requester logic (UART/packet front-ends) and a single rsa_decoder instance.

Parameters:
- K, 12, data width; matches the core's k.
- NREQ, 4, number of requesters (>=2).
- TIMEOUT, 4096, maximum WAIT cycles before abort (>=2).
- TW, 13, watchdog counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NREQ  per-requester request; held with data until its req_ready pulse.
- req_data  in  NREQ*K  requester i occupies bits [i*K +: K].
- req_ready  out  NREQ  one-hot acceptance pulse, 1 cycle.
- rsp_valid  out  NREQ  one-hot response pulse, 1 cycle.
- rsp_data  out  K  result; valid only while rsp_valid != 0.
- rsp_err  out  1  timeout flag; valid only while rsp_valid != 0.
- core_start  out  1  level start to the core.
- core_data  out  K  core data_in; stable from LAUNCH through WAIT.
- core_done  in  1  core completion.
- core_result  in  K  core data_out; valid when core_done=1.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, ptr=NREQ-1 (requester 0 wins first), watchdog=0.
  - All outputs 0, including core_start, core_data and rsp_data.
- FSM states: IDLE, LAUNCH, WAIT, RESP. All outputs are registered or decoded from state only; no combinational path from any input to any output.
- IDLE:
  - If any req_valid is high, select g = first set bit searching ptr+1, ptr+2, … with wrap modulo NREQ.
  - Latch req_data[g] into core_data and g into gnt.
  - Next state is LAUNCH.
  - If no req_valid is high, stay in IDLE.
- LAUNCH (1 cycle):
  - req_ready[gnt]=1 and core_start=1.
  - Clear watchdog. Next state is WAIT.
  - The requester must drop req_valid in the cycle after seeing req_ready.
- WAIT:
  - core_start stays 1; watchdog increments every cycle.
  - If core_done=1: latch core_result into rsp_data, set err=0, go to RESP. core_done is sampled only in WAIT.
  - Else if watchdog==TIMEOUT-1: set rsp_data=0, err=1, go to RESP.
  - If core_done=1 and the timeout condition hold in the same cycle, done wins.
- RESP (1 cycle):
  - rsp_valid[gnt]=1 and rsp_err=err; core_start=0.
  - ptr<=gnt. Next state is IDLE.
- core_start is low in RESP and IDLE, so there are at least 2 low cycles between jobs (core re-arm).
- core_done while in IDLE, LAUNCH or RESP is ignored.
- Latency:
  - Request to req_ready: 1 cycle.
  - core_done to rsp_valid: 1 cycle.
  - A request seen in IDLE at edge t gives core_start high from t+1.
- req_valid changes during LAUNCH/WAIT/RESP do not affect the current job. New requests wait for the next IDLE.
- Reset mid-job: the job is dropped with no rsp_valid. core_start is 0 from the reset edge.
- Fairness: with all NREQ requesting continuously, grants rotate 0,1,…,NREQ-1,0. Each requester waits at most NREQ-1 jobs.

Test Plan:
- Single job: reset, then req_valid[0]=1 with data 2959 against a real rsa_decoder (n=3551, d=1373, k=12, exp_2k=2292) -> req_ready[0] pulses once; rsp_valid[0] pulses once; rsp_data equals the software model of 2959^1373 mod 3551; rsp_err=0.
- Round-robin: stub core returning data+1 after 5 cycles; all 4 requesters hold valid with data 10, 20, 30, 40 -> grant order 0,1,2,3,0; responses 11, 21, 31, 41 on the matching rsp_valid bits.
- Fairness after ptr move: after requester 2 is served, requesters 1 and 3 request together -> 3 is granted before 1.
- Timeout: TIMEOUT=16 and a stub that never raises done -> rsp_valid pulses exactly 16 WAIT cycles after LAUNCH with rsp_err=1 and rsp_data=0; the next job proceeds normally.
- Done/timeout collision: stub raises done in the same cycle the watchdog reaches 15 -> rsp_err=0 and the result is delivered.
- Reset mid-WAIT: assert rst for 1 cycle during WAIT -> no rsp_valid, core_start=0, busy=0, ptr=NREQ-1; a following request from requester 0 completes normally.
